// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one bus request at a time, holds the fetched word for decode,
// and steers to redirect targets, discarding any response that belongs to a stale address.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect_valid,
    input  logic [63:0] i_redirect_pc,
    output logic        o_ireq_valid,
    output logic [63:0] o_ireq_addr,
    input  logic        i_iresp_addr_ok,
    input  logic        i_iresp_data_ok,
    input  logic [31:0] i_iresp_data,
    output logic        o_if_valid,
    output logic [63:0] o_if_pc,
    output logic [31:0] o_if_instr,
    input  logic        i_id_ready
);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [63:0] r_pc;
    logic [63:0] w_pc_next;
    logic [63:0] r_req_addr;
    logic [63:0] w_req_addr_next;
    logic        r_drop;
    logic        w_drop_next;
    logic        r_if_valid;
    logic        w_if_valid_next;
    logic [63:0] r_if_pc;
    logic [63:0] w_if_pc_next;
    logic [31:0] r_if_instr;
    logic [31:0] w_if_instr_next;
    logic [63:0] w_pc_plus4;

    // Modulo 2^64 by construction: the carry out of bit 63 is simply lost.
    assign w_pc_plus4 = r_pc + 64'd4;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StReq;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 64'd0;
            r_if_instr <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_req_addr <= w_req_addr_next;
            r_drop     <= w_drop_next;
            r_if_valid <= w_if_valid_next;
            r_if_pc    <= w_if_pc_next;
            r_if_instr <= w_if_instr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_req_addr_next = r_req_addr;
        w_drop_next     = r_drop;
        w_if_valid_next = r_if_valid;
        w_if_pc_next    = r_if_pc;
        w_if_instr_next = r_if_instr;

        unique case (r_state)
            StReq: begin
                // The request address stays put on redirect; its response is dropped later.
                if (i_redirect_valid) begin
                    w_pc_next   = i_redirect_pc;
                    w_drop_next = 1'b1;
                end
                if (i_iresp_addr_ok) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (i_iresp_data_ok) begin
                    if (r_drop || i_redirect_valid) begin
                        w_drop_next  = 1'b0;
                        w_state_next = StReq;
                        if (i_redirect_valid) begin
                            w_pc_next       = i_redirect_pc;
                            w_req_addr_next = i_redirect_pc;
                        end else begin
                            w_req_addr_next = r_pc;
                        end
                    end else begin
                        w_if_valid_next = 1'b1;
                        w_if_pc_next    = r_pc;
                        w_if_instr_next = i_iresp_data;
                        w_state_next    = StHold;
                    end
                end else if (i_redirect_valid) begin
                    w_pc_next   = i_redirect_pc;
                    w_drop_next = 1'b1;
                end
            end
            StHold: begin
                // Redirect beats a same-cycle decode accept: the held word is squashed.
                if (i_redirect_valid) begin
                    w_if_valid_next = 1'b0;
                    w_pc_next       = i_redirect_pc;
                    w_req_addr_next = i_redirect_pc;
                    w_state_next    = StReq;
                end else if (i_id_ready) begin
                    w_if_valid_next = 1'b0;
                    w_pc_next       = w_pc_plus4;
                    w_req_addr_next = w_pc_plus4;
                    w_state_next    = StReq;
                end
            end
            default: begin
                w_state_next = StReq;
            end
        endcase
    end

    assign o_ireq_valid = (r_state == StReq);
    assign o_ireq_addr  = r_req_addr;
    assign o_if_valid   = r_if_valid;
    assign o_if_pc      = r_if_pc;
    assign o_if_instr   = r_if_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each scenario task drives the bus/decode handshakes and checks
// the registered outputs 1 time unit after the rising edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    int checks = 0;
    int failures = 0;

    fetch_unit #(
        .RESET_PC(64'h0000_0000_8000_0000)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_ireq_valid    (ireq_valid),
        .o_ireq_addr     (ireq_addr),
        .i_iresp_addr_ok (iresp_addr_ok),
        .i_iresp_data_ok (iresp_data_ok),
        .i_iresp_data    (iresp_data),
        .o_if_valid      (if_valid),
        .o_if_pc         (if_pc),
        .o_if_instr      (if_instr),
        .i_id_ready      (id_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'd0;
        id_ready       = 1'b0;
    endtask

    // Checks that a request for exp_addr is pending and nothing is presented to decode.
    task automatic expect_req(input string name, input logic [63:0] exp_addr);
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== exp_addr || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s: ireq_valid=%b ireq_addr=%h if_valid=%b, want 1 %h 0",
                     name, ireq_valid, ireq_addr, if_valid, exp_addr);
        end
    endtask

    // Completes a clean fetch from REQ: addr_ok, then data_ok with word; lands in HOLD.
    task automatic fetch(input string name, input logic [63:0] exp_pc, input logic [31:0] word);
        idle();
        iresp_addr_ok = 1'b1;
        tick();
        checks++;
        if (ireq_valid !== 1'b0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_wait: ireq_valid=%b if_valid=%b, want 0 0",
                     name, ireq_valid, if_valid);
        end
        idle();
        iresp_data_ok = 1'b1;
        iresp_data    = word;
        tick();
        idle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== word || ireq_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_hold: if_valid=%b if_pc=%h if_instr=%h ireq_valid=%b, want 1 %h %h 0",
                     name, if_valid, if_pc, if_instr, ireq_valid, exp_pc, word);
        end
    endtask

    task automatic test_reset();
        idle();
        reset         = 1'b1;
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        id_ready      = 1'b1;
        tick();
        tick();
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 64'd0 || if_instr !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: if_valid=%b if_pc=%h if_instr=%h, want 0 0 0",
                     if_valid, if_pc, if_instr);
        end
        idle();
        expect_req("reset_first_req", 64'h0000_0000_8000_0000);
    endtask

    task automatic test_basic_and_hold();
        fetch("basic", 64'h0000_0000_8000_0000, 32'h0010_0093);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 64'h0000_0000_8000_0000 ||
                if_instr !== 32'h0010_0093 || ireq_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: if_valid=%b if_pc=%h if_instr=%h ireq_valid=%b",
                         i, if_valid, if_pc, if_instr, ireq_valid);
            end
        end
        id_ready = 1'b1;
        tick();
        idle();
        expect_req("basic_next_addr", 64'h0000_0000_8000_0004);
    endtask

    task automatic test_redirect_wait();
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0100;
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (ireq_valid !== 1'b0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_wait_stay: ireq_valid=%b if_valid=%b, want 0 0",
                     ireq_valid, if_valid);
        end
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0013;
        tick();
        idle();
        expect_req("redir_wait_discard", 64'h0000_0000_8000_0100);
        fetch("redir_wait_refetch", 64'h0000_0000_8000_0100, 32'h1111_1111);
    endtask

    task automatic test_redirect_hold();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0400;
        id_ready       = 1'b1;
        tick();
        idle();
        expect_req("redir_hold_wins", 64'h0000_0000_8000_0400);
        fetch("redir_hold_fetch", 64'h0000_0000_8000_0400, 32'h2222_2222);
        id_ready = 1'b1;
        tick();
        idle();
        expect_req("redir_hold_next", 64'h0000_0000_8000_0404);
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_0000_0100;
        tick();
        expect_req("b2b_addr_stable1", 64'h0000_0000_8000_0404);
        redirect_pc = 64'h0000_0000_0000_0200;
        tick();
        idle();
        expect_req("b2b_addr_stable2", 64'h0000_0000_8000_0404);
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h3333_3333;
        tick();
        idle();
        expect_req("b2b_discard_one", 64'h0000_0000_0000_0200);
        fetch("b2b_fetch", 64'h0000_0000_0000_0200, 32'h4444_4444);
        id_ready = 1'b1;
        tick();
        idle();
        expect_req("b2b_next", 64'h0000_0000_0000_0204);
    endtask

    task automatic test_redirect_edges();
        // Redirect with same-cycle addr_ok, then redirect with same-cycle data_ok.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_0000_0300;
        iresp_addr_ok  = 1'b1;
        tick();
        idle();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h5555_5555;
        tick();
        idle();
        expect_req("redir_addr_ok", 64'h0000_0000_0000_0300);
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'h6666_6666;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_0000_0500;
        tick();
        idle();
        expect_req("redir_data_ok", 64'h0000_0000_0000_0500);
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        idle();
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        iresp_data_ok = 1'b1;
        tick();
        idle();
        expect_req("wrap_req", 64'hFFFF_FFFF_FFFF_FFFC);
        fetch("wrap_fetch", 64'hFFFF_FFFF_FFFF_FFFC, 32'h7777_7777);
        id_ready = 1'b1;
        tick();
        idle();
        expect_req("wrap_zero", 64'd0);
    endtask

    task automatic test_reset_mid();
        iresp_addr_ok = 1'b1;
        tick();
        idle();
        reset = 1'b1;
        tick();
        idle();
        expect_req("reset_mid_req", 64'h0000_0000_8000_0000);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h8888_8888;
        tick();
        idle();
        expect_req("reset_mid_ignore", 64'h0000_0000_8000_0000);
        fetch("reset_mid_fetch", 64'h0000_0000_8000_0000, 32'h9999_9999);
    endtask

    initial begin
        idle();
        test_reset();
        test_basic_and_hold();
        test_redirect_wait();
        test_redirect_hold();
        test_back_to_back();
        test_redirect_edges();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 redirect_valid  input  1  control-flow redirect from pc_select path (taken branch, JAL, JALR).
REQ-005 redirect_pc  input  64  redirect target (pc_next of the redirecting instruction).
REQ-006 ireq_valid  output  1  instruction-bus request valid.
REQ-007 ireq_addr  output  64  instruction-bus request address.
REQ-008 iresp_addr_ok  input  1  bus accepted the request this cycle.
REQ-009 iresp_data_ok  input  1  response data valid this cycle.
REQ-010 iresp_data  input  32  fetched instruction word.
REQ-011 if_valid  output  1  fetched instruction valid to decode.
REQ-012 if_pc  output  64  PC of the instruction on if_instr.
REQ-013 if_instr  output  32  fetched instruction.
REQ-014 id_ready  input  1  decode accepts the instruction this cycle.

Function
REQ-015 The block SHALL hold a 64-bit pc register, a 64-bit req_addr register, a 1-bit drop flag, and an output register (if_valid, if_pc, if_instr).
REQ-016 FSM states SHALL be REQ, WAIT, HOLD; ireq_valid = (state == REQ); ireq_addr = req_addr.
REQ-017 REQ: on iresp_addr_ok -> WAIT; else stay REQ with ireq_valid and ireq_addr unchanged (address stable until accepted).
REQ-018 WAIT: on iresp_data_ok with drop==0 and no redirect -> load if_instr=iresp_data, if_pc=pc, if_valid=1, -> HOLD.
REQ-019 WAIT: on iresp_data_ok with drop==1 -> discard data, clear drop, req_addr=pc, -> REQ.
REQ-020 HOLD: on id_ready -> if_valid=0, pc=pc+4, req_addr=pc+4, -> REQ; else hold all outputs stable.
REQ-021 PC arithmetic SHALL be 64-bit modulo 2^64; pc+4 from 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-022 Redirect in HOLD SHALL clear if_valid, set pc=req_addr=redirect_pc, -> REQ; redirect wins over same-cycle id_ready (pc not incremented).
REQ-023 Redirect in REQ without addr_ok SHALL set pc=redirect_pc and drop=1, stay REQ with req_addr unchanged (in-flight address finishes, result discarded).
REQ-024 Redirect in REQ with same-cycle addr_ok SHALL set pc=redirect_pc, drop=1, -> WAIT.
REQ-025 Redirect in WAIT without data_ok SHALL set pc=redirect_pc, drop=1, stay WAIT.
REQ-026 Redirect in WAIT with same-cycle data_ok SHALL discard data, clear drop, set pc=req_addr=redirect_pc, -> REQ.
REQ-027 Back-to-back redirects SHALL leave pc equal to the last redirect_pc; drop stays 1 until one response is discarded.
REQ-028 In REQ with drop==1, after addr_ok -> WAIT; the following data_ok is discarded per REQ-019, then req_addr=pc is issued.
REQ-029 No instruction SHALL reach if_valid whose address differs from the current architectural pc.
REQ-030 Best-case latency: request issued cycle N, addr_ok N, data_ok N+1, if_valid=1 from N+2.

Reset
REQ-031 While reset is high at a clock edge: pc=req_addr=RESET_PC, state=REQ, drop=0, if_valid=0, if_pc=0, if_instr=0.
REQ-032 First cycle after reset deassertion: ireq_valid=1, ireq_addr=RESET_PC.
REQ-033 Reset mid-transaction SHALL abandon any outstanding request; a data_ok arriving in REQ after reset SHALL be ignored.

Verification
REQ-034 Reset release, addr_ok same cycle, data_ok next, id_ready=1 -> if_pc=0x8000_0000 valid 2 cycles after request, next ireq_addr=0x8000_0004.
REQ-035 HOLD with id_ready=0 for 5 cycles -> if_valid/if_pc/if_instr stable, ireq_valid=0 throughout.
REQ-036 Redirect to 0x8000_0100 in WAIT, data_ok 3 cycles later with 0x0000_0013 -> data discarded, next ireq_addr=0x8000_0100, no if_valid for old word.
REQ-037 Redirect and id_ready same cycle in HOLD -> pc=redirect_pc, ireq_addr=redirect_pc, not old pc+4.
REQ-038 Two redirects (0x100 then 0x200) while addr_ok withheld -> one response discarded, next fetch address 0x200.
REQ-039 pc=0xFFFF_FFFF_FFFF_FFFC accepted by decode -> next ireq_addr=0.
